// File: rtl/morph_frame_if.sv
// Video timing, host mode request and pipeline control bundle for morph_frame_ctrl.
// The master side is the video source / host; the slave side is the frame sequencer.
interface morph_frame_if #(
  parameter int W_BITS = 11
);
  logic              in_de;
  logic              in_hsync;
  logic              in_vsync;
  logic [1:0]        mode_req;
  logic              mode_req_valid;
  logic [W_BITS-1:0] h_size;
  logic [1:0]        mode;
  logic              mode_ack;
  logic              pipe_rst;
  logic              pipe_ce;
  logic              locked;
  logic              width_err;

  modport master (
    output in_de, in_hsync, in_vsync, mode_req, mode_req_valid,
    input  h_size, mode, mode_ack, pipe_rst, pipe_ce, locked, width_err
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, mode_req, mode_req_valid,
    output h_size, mode, mode_ack, pipe_rst, pipe_ce, locked, width_err
  );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Frame-level sequencer for the 3x3 binary morphology stage: measures line width,
// locks geometry before releasing the pipeline, and switches mode only at frame start.
module morph_frame_ctrl #(
  parameter int W_BITS     = 11,
  parameter int MAX_W      = 1920,
  parameter int LOCK_LINES = 4
) (
  input  logic         clk,
  input  logic         rst,
  morph_frame_if.slave bus
);

  localparam int                  MC_BITS = $clog2(LOCK_LINES + 1);
  localparam logic [W_BITS-1:0]   MAX_W_C = W_BITS'(MAX_W);
  localparam logic [W_BITS-1:0]   SAT_C   = W_BITS'(MAX_W + 1);
  localparam logic [MC_BITS-1:0]  LOCK_C  = MC_BITS'(LOCK_LINES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_ARM  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  state_e              state_q;
  logic                vsync_q;
  logic                de_q;
  logic [W_BITS-1:0]   cnt_q;
  logic [W_BITS-1:0]   cnt_d;
  logic [W_BITS-1:0]   ref_q;
  logic [MC_BITS-1:0]  match_q;
  logic [W_BITS-1:0]   h_size_q;
  logic [1:0]          mode_q;
  logic [1:0]          pend_q;
  logic                pend_v_q;
  logic                mode_ack_q;
  logic                pipe_rst_q;
  logic                pipe_ce_q;
  logic                locked_q;
  logic                width_err_q;

  logic                fs_s;
  logic                le_s;
  logic                line_ok_s;
  logic                meas_hit_s;
  logic                meas_lock_s;
  logic                run_bad_s;
  logic                apply_s;
  logic [MC_BITS-1:0]  match_inc_s;

  // Frame/line events and the per-line decisions taken from the current width.
  always_comb begin
    fs_s        = bus.in_vsync & ~vsync_q;
    le_s        = de_q & ~bus.in_de;
    line_ok_s   = (cnt_q <= MAX_W_C);
    match_inc_s = match_q + MC_BITS'(1);
    meas_hit_s  = le_s & line_ok_s & (cnt_q == ref_q);
    meas_lock_s = meas_hit_s & (match_inc_s == LOCK_C);
    run_bad_s   = le_s & ~(line_ok_s & (cnt_q == h_size_q));
    // A mismatching line end in RUN wins over a coincident frame start.
    apply_s     = fs_s & pend_v_q &
                  ((state_q == ST_ARM) | ((state_q == ST_RUN) & ~run_bad_s));
  end

  // Line-length counter; saturates one past the widest legal line.
  always_comb begin
    if (bus.in_de & ~de_q) begin
      cnt_d = W_BITS'(1);
    end else if (bus.in_de & (cnt_q != SAT_C)) begin
      cnt_d = cnt_q + W_BITS'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Delayed timing inputs and the line counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vsync_q <= bus.in_vsync;
      de_q    <= bus.in_de;
      cnt_q   <= cnt_d;
    end
  end

  // Geometry lock state machine with registered pipeline controls and mode handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ref_q       <= '0;
      match_q     <= '0;
      h_size_q    <= '0;
      mode_q      <= 2'd0;
      pend_q      <= 2'd0;
      pend_v_q    <= 1'b0;
      mode_ack_q  <= 1'b0;
      pipe_rst_q  <= 1'b1;
      pipe_ce_q   <= 1'b0;
      locked_q    <= 1'b0;
      width_err_q <= 1'b0;
    end else begin
      mode_ack_q  <= 1'b0;
      width_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pipe_rst_q <= 1'b1;
          pipe_ce_q  <= 1'b0;
          locked_q   <= 1'b0;
          if (fs_s) begin
            state_q <= ST_MEAS;
            match_q <= '0;
          end
        end
        ST_MEAS: begin
          if (le_s & ~meas_hit_s) begin
            ref_q <= cnt_q;
          end
          // The line end is judged first; a coincident frame start then restarts the count.
          if (meas_lock_s) begin
            h_size_q <= ref_q;
            match_q  <= '0;
            state_q  <= ST_ARM;
          end else if (fs_s) begin
            match_q <= '0;
          end else if (meas_hit_s) begin
            match_q <= match_inc_s;
          end else if (le_s) begin
            match_q <= MC_BITS'(1);
          end
        end
        ST_ARM: begin
          if (fs_s) begin
            state_q    <= ST_RUN;
            pipe_rst_q <= 1'b0;
            pipe_ce_q  <= 1'b1;
            locked_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (run_bad_s) begin
            state_q     <= ST_IDLE;
            width_err_q <= 1'b1;
            locked_q    <= 1'b0;
            pipe_rst_q  <= 1'b1;
            pipe_ce_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          pipe_rst_q <= 1'b1;
          pipe_ce_q  <= 1'b0;
          locked_q   <= 1'b0;
        end
      endcase

      if (apply_s) begin
        mode_q     <= pend_q;
        mode_ack_q <= 1'b1;
        pend_v_q   <= 1'b0;
      end
      // A strobe coinciding with an apply becomes the next pending request.
      if (bus.mode_req_valid) begin
        pend_q   <= bus.mode_req;
        pend_v_q <= 1'b1;
      end
    end
  end

  assign bus.h_size    = h_size_q;
  assign bus.mode      = mode_q;
  assign bus.mode_ack  = mode_ack_q;
  assign bus.pipe_rst  = pipe_rst_q;
  assign bus.pipe_ce   = pipe_ce_q;
  assign bus.locked    = locked_q;
  assign bus.width_err = width_err_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Bench for morph_frame_ctrl: a frame/line-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_morph_frame_ctrl;
  localparam int W_BITS     = 11;
  localparam int MAX_W      = 1920;
  localparam int LOCK_LINES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morph_frame_if #(.W_BITS(W_BITS)) bus ();

  morph_frame_ctrl #(
    .W_BITS(W_BITS), .MAX_W(MAX_W), .LOCK_LINES(LOCK_LINES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ack_seen = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 measuring, 2 armed, 3 running.
  int  m_phase = 0;
  int  m_widths[$];
  int  m_len = 0;
  bit  m_vs = 1'b0, m_de = 1'b0;
  bit  m_pv = 1'b0;
  int  m_pd = 0;
  int  e_h = 0, e_mode = 0;
  bit  e_ack = 1'b0, e_prst = 1'b1, e_ce = 1'b0, e_lock = 1'b0, e_err = 1'b0;
  bit  mf, ml;
  int  mw;

  function automatic bit lock_ok();
    int n;
    n = m_widths.size();
    if (n < LOCK_LINES) return 1'b0;
    if (m_widths[n-1] > MAX_W) return 1'b0;
    for (int i = 1; i < LOCK_LINES; i++)
      if (m_widths[n-1-i] != m_widths[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_widths.delete(); m_len = 0; m_vs = 1'b0; m_de = 1'b0;
      m_pv = 1'b0; m_pd = 0; e_h = 0; e_mode = 0;
      e_ack = 1'b0; e_prst = 1'b1; e_ce = 1'b0; e_lock = 1'b0; e_err = 1'b0;
    end else begin
      mf = bus.in_vsync && !m_vs;
      ml = m_de && !bus.in_de;
      mw = m_len;
      e_ack = 1'b0;
      e_err = 1'b0;
      case (m_phase)
        0: if (mf) begin m_phase = 1; m_widths.delete(); end
        1: begin
          if (ml) begin
            m_widths.push_back(mw);
            if (lock_ok()) begin e_h = mw; m_phase = 2; end
          end
          if (mf && m_phase == 1) m_widths.delete();
        end
        2: if (mf) begin
          m_phase = 3; e_prst = 1'b0; e_ce = 1'b1; e_lock = 1'b1;
          if (m_pv) begin e_mode = m_pd; e_ack = 1'b1; m_pv = 1'b0; end
        end
        3: if (ml && (mw != e_h || mw > MAX_W)) begin
          m_phase = 0; e_err = 1'b1; e_lock = 1'b0; e_prst = 1'b1; e_ce = 1'b0;
        end else if (mf && m_pv) begin
          e_mode = m_pd; e_ack = 1'b1; m_pv = 1'b0;
        end
        default: m_phase = 0;
      endcase
      if (bus.mode_req_valid) begin m_pd = int'(bus.mode_req); m_pv = 1'b1; end
      if (bus.in_de && !m_de) m_len = 1;
      else if (bus.in_de) m_len++;
      m_vs = bus.in_vsync;
      m_de = bus.in_de;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("h_size",    bus.h_size,    e_h);
      check("mode",      bus.mode,      e_mode);
      check("mode_ack",  bus.mode_ack,  e_ack);
      check("pipe_rst",  bus.pipe_rst,  e_prst);
      check("pipe_ce",   bus.pipe_ce,   e_ce);
      check("locked",    bus.locked,    e_lock);
      check("width_err", bus.width_err, e_err);
      if (bus.mode_ack)  ack_seen++;
      if (bus.width_err) err_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fstart(input int strobe_m);
    @(negedge clk);
    bus.in_vsync = 1'b1;
    if (strobe_m >= 0) begin
      bus.mode_req = 2'(strobe_m);
      bus.mode_req_valid = 1'b1;
    end
    @(negedge clk);
    bus.mode_req_valid = 1'b0;
    cyc(2);
    bus.in_vsync = 1'b0;
    cyc(3);
  endtask

  task automatic line(input int w);
    bus.in_de = 1'b1;
    cyc(w);
    bus.in_de = 1'b0;
    bus.in_hsync = 1'b1;
    cyc(2);
    bus.in_hsync = 1'b0;
    cyc(3);
  endtask

  task automatic strobe(input int m);
    bus.mode_req = 2'(m);
    bus.mode_req_valid = 1'b1;
    cyc(1);
    bus.mode_req_valid = 1'b0;
    cyc(1);
  endtask

  task automatic frame(input int w, input int n);
    fstart(-1);
    repeat (n) line(w);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_h_size"},    bus.h_size,    32'd0);
    check({tag, "_mode"},      bus.mode,      32'd0);
    check({tag, "_mode_ack"},  bus.mode_ack,  32'd0);
    check({tag, "_pipe_rst"},  bus.pipe_rst,  32'd1);
    check({tag, "_pipe_ce"},   bus.pipe_ce,   32'd0);
    check({tag, "_locked"},    bus.locked,    32'd0);
    check({tag, "_width_err"}, bus.width_err, 32'd0);
  endtask

  int a0, e0;

  initial begin
    bus.in_de = 1'b0; bus.in_hsync = 1'b0; bus.in_vsync = 1'b0;
    bus.mode_req = 2'd0; bus.mode_req_valid = 1'b0;
    cyc(3);
    check_reset_values("reset");
    rst = 1'b0;
    cyc(2);

    // Lock onto 83-pixel lines
    frame(83, 6);
    check("t1_arm_locked", bus.locked, 32'd0);
    check("t1_arm_pipe_rst", bus.pipe_rst, 32'd1);
    fstart(-1);
    check("t1_h_size", bus.h_size, 32'd83);
    check("t1_locked", bus.locked, 32'd1);
    check("t1_pipe_rst", bus.pipe_rst, 32'd0);
    check("t1_pipe_ce", bus.pipe_ce, 32'd1);
    repeat (6) line(83);

    // One short line drops lock; relock needs two frame starts
    fstart(-1);
    line(83);
    e0 = err_seen;
    line(82);
    check("t2_err_pulses", err_seen - e0, 32'd1);
    check("t2_locked", bus.locked, 32'd0);
    check("t2_pipe_rst", bus.pipe_rst, 32'd1);
    check("t2_pipe_ce", bus.pipe_ce, 32'd0);
    repeat (3) line(83);
    frame(83, 6);
    check("t2_fs1_locked", bus.locked, 32'd0);
    fstart(-1);
    check("t2_fs2_locked", bus.locked, 32'd1);
    repeat (6) line(83);

    // Mid-frame request waits for the frame start
    fstart(-1);
    line(83);
    a0 = ack_seen;
    strobe(3);
    line(83);
    check("t3_mode_before_fs", bus.mode, 32'd0);
    check("t3_no_early_ack", ack_seen - a0, 32'd0);
    repeat (4) line(83);
    fstart(-1);
    check("t3_mode_after_fs", bus.mode, 32'd3);
    check("t3_ack_count", ack_seen - a0, 32'd1);
    repeat (6) line(83);

    // Strobe on the fs cycle is deferred, later strobe overwrites it
    a0 = ack_seen;
    fstart(1);
    check("t4_mode_at_fs", bus.mode, 32'd3);
    check("t4_no_ack_at_fs", ack_seen - a0, 32'd0);
    line(83);
    strobe(2);
    repeat (5) line(83);
    fstart(-1);
    check("t4_mode_next_fs", bus.mode, 32'd2);
    check("t4_single_ack", ack_seen - a0, 32'd1);
    repeat (6) line(83);

    // Request equal to the current mode is still acknowledged
    a0 = ack_seen;
    strobe(2);
    line(83);
    fstart(-1);
    check("t4b_mode_same", bus.mode, 32'd2);
    check("t4b_ack", ack_seen - a0, 32'd1);
    repeat (6) line(83);

    // Over-wide lines never lock; then 640-pixel lines do
    fstart(-1);
    line(MAX_W + 5);
    check("t5_drop_locked", bus.locked, 32'd0);
    repeat (2) begin
      frame(MAX_W + 5, 5);
      check("t5_wide_locked", bus.locked, 32'd0);
      check("t5_wide_pipe_rst", bus.pipe_rst, 32'd1);
    end
    frame(640, 5);
    check("t5_arm_h_size", bus.h_size, 32'd640);
    check("t5_arm_locked", bus.locked, 32'd0);
    fstart(-1);
    check("t5_locked", bus.locked, 32'd1);
    check("t5_h_size", bus.h_size, 32'd640);
    check("t5_mode_held", bus.mode, 32'd2);

    // Asynchronous reset in the middle of a running line
    a0 = ack_seen;
    bus.in_de = 1'b1;
    cyc(100);
    #2 rst = 1'b1;
    #1 check_reset_values("t6_async");
    cyc(2);
    bus.in_de = 1'b0;
    rst = 1'b0;
    cyc(3);
    repeat (5) line(640);
    check("t6_no_fs_locked", bus.locked, 32'd0);
    check("t6_no_fs_pipe_rst", bus.pipe_rst, 32'd1);
    frame(640, 5);
    check("t6_fs1_locked", bus.locked, 32'd0);
    fstart(-1);
    check("t6_relock", bus.locked, 32'd1);
    check("t6_h_size", bus.h_size, 32'd640);
    check("t6_mode", bus.mode, 32'd0);
    check("t6_no_ack", ack_seen - a0, 32'd0);
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
